b2r_slice_converter: RTL

Block-to-row converter feeding the self-attention head. Accepts square BLOCK_SIZE x BLOCK_SIZE result blocks from the systolic array and re-emits them as row chunks in raster order. Raises `slice_done_b2r_wrap` once a full slice (COL_BLOCKS x ROW_BLOCKS blocks) has been emitted, then holds until the attention controller drives the active-low rearm input `internal_rst_n_b2r`.

---
 rtl/b2r_slice_converter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/b2r_slice_converter.sv
// Block-to-row converter: buffers one block-row of BLOCK_SIZE x BLOCK_SIZE blocks,
// then re-emits it as row chunks in raster order; flags completion of a full slice.
module b2r_slice_converter #(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int ROW_BLOCKS = 4,
  parameter int COL_BLOCKS = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                internal_rst_n_b2r,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [BLOCK_SIZE*WIDTH-1:0]         out_data,
  output logic                                out_row_last,
  output logic                                out_last,
  output logic                                slice_done_b2r_wrap
);

  localparam int BLK_W = BLOCK_SIZE * BLOCK_SIZE * WIDTH;
  localparam int ROW_W = BLOCK_SIZE * WIDTH;
  localparam int BI_W  = (ROW_BLOCKS > 1) ? $clog2(ROW_BLOCKS) : 1;
  localparam int R_W   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int BR_W  = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;

  localparam logic [BI_W-1:0] BI_LAST = BI_W'(ROW_BLOCKS - 1);
  localparam logic [BI_W-1:0] BI_ONE  = BI_W'(1);
  localparam logic [R_W-1:0]  R_LAST  = R_W'(BLOCK_SIZE - 1);
  localparam logic [R_W-1:0]  R_ONE   = R_W'(1);
  localparam logic [BR_W-1:0] BR_LAST = BR_W'(COL_BLOCKS - 1);
  localparam logic [BR_W-1:0] BR_ONE  = BR_W'(1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state_r;
  logic [BI_W-1:0] blk_idx_r;
  logic [BI_W-1:0] col_idx_r;
  logic [R_W-1:0]  row_idx_r;
  logic [BR_W-1:0] brow_idx_r;
  logic [BLK_W-1:0] buffer_r [ROW_BLOCKS];

  // Handshake qualifiers; the rearm input gates both sides so an abort cycle completes nothing.
  always_comb begin
    in_ready            = 1'b0;
    out_valid           = 1'b0;
    out_row_last        = 1'b0;
    out_last            = 1'b0;
    out_data            = '0;
    slice_done_b2r_wrap = 1'b0;
    if (!rst && internal_rst_n_b2r) begin
      in_ready  = (state_r == ST_FILL);
      out_valid = (state_r == ST_DRAIN);
    end else begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
    if (out_valid) begin
      out_data     = buffer_r[col_idx_r][row_idx_r*ROW_W +: ROW_W];
      out_row_last = (col_idx_r == BI_LAST);
      out_last     = (col_idx_r == BI_LAST) && (row_idx_r == R_LAST) && (brow_idx_r == BR_LAST);
    end else begin
      out_data     = '0;
      out_row_last = 1'b0;
      out_last     = 1'b0;
    end
    slice_done_b2r_wrap = (state_r == ST_DONE) && !rst;
  end

  // Block storage; contents are don't-care after reset or abort, so no reset here.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      buffer_r[blk_idx_r] <= in_data;
    end
  end

  // Fill/drain/done sequencing and raster counters.
  always_ff @(posedge clk) begin
    if (rst || !internal_rst_n_b2r) begin
      state_r    <= ST_FILL;
      blk_idx_r  <= '0;
      col_idx_r  <= '0;
      row_idx_r  <= '0;
      brow_idx_r <= '0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (in_valid) begin
            if (blk_idx_r == BI_LAST) begin
              blk_idx_r <= '0;
              row_idx_r <= '0;
              col_idx_r <= '0;
              state_r   <= ST_DRAIN;
            end else begin
              blk_idx_r <= blk_idx_r + BI_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (col_idx_r == BI_LAST) begin
              col_idx_r <= '0;
              if (row_idx_r == R_LAST) begin
                row_idx_r <= '0;
                if (brow_idx_r == BR_LAST) begin
                  state_r <= ST_DONE;
                end else begin
                  brow_idx_r <= brow_idx_r + BR_ONE;
                  state_r    <= ST_FILL;
                end
              end else begin
                row_idx_r <= row_idx_r + R_ONE;
              end
            end else begin
              col_idx_r <= col_idx_r + BI_ONE;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_FILL;
        end
      endcase
    end
  end

endmodule
